// File: rtl/ecc_pkg.sv
// Shared types and constants for the elliptic-curve point-multiplication path.
package ecc_pkg;

  // Coordinate and scalar width used when a block is not overridden.
  localparam int DEFAULT_DATA_WIDTH = 256;

  // Point-engine operation select.
  localparam logic OP_DBL = 1'b0;  // R = 2A
  localparam logic OP_ADD = 1'b1;  // R = A + B

  // Double-and-add sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    DBL,
    DBL_W,
    ADD,
    ADD_W,
    DONE
  } state_t;

  // Affine point with an explicit point-at-infinity flag.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] x;
    logic [DEFAULT_DATA_WIDTH-1:0] y;
    logic                          inf;
  } affine_pt_t;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer computing R = k*P. Trivial cases
// (infinity operand, P+P, P+(-P)) are resolved here; every other doubling or
// addition is issued to an external point engine over a req/done handshake.
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] Px,
  input  logic [DATA_WIDTH-1:0] Py,
  input  logic [DATA_WIDTH-1:0] k,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] Rx,
  output logic [DATA_WIDTH-1:0] Ry,
  output logic                  R_inf,
  output logic                  op_req,
  output logic                  op_sel,
  output logic [DATA_WIDTH-1:0] op_ax,
  output logic [DATA_WIDTH-1:0] op_ay,
  output logic [DATA_WIDTH-1:0] op_bx,
  output logic [DATA_WIDTH-1:0] op_by,
  input  logic                  op_done,
  input  logic [DATA_WIDTH-1:0] op_rx,
  input  logic [DATA_WIDTH-1:0] op_ry,
  input  logic                  op_inf
);

  // Local point type sized to this instance's coordinate width.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic                  inf;
  } pt_t;

  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  pt_t                   acc;      // running accumulator
  pt_t                   base;     // latched base point P
  logic [DATA_WIDTH-1:0] k_reg;    // latched scalar
  logic [CNT_W-1:0]      idx;      // scalar bit under evaluation

  logic bit_set;
  logic x_eq;
  logic y_eq;
  logic add_call;   // ADD step needs the engine
  logic add_sel;    // engine op for that call
  logic bit_done;   // the current scalar bit is fully processed this cycle
  pt_t  nxt;        // accumulator value once the current bit completes

  assign bit_set = k_reg[idx];
  assign x_eq    = (acc.x == base.x);
  assign y_eq    = (acc.y == base.y);

  // Resolve the ADD step: decide between an internal shortcut and an engine
  // call, and form the accumulator value that closes out the current bit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    nxt.x    = op_rx;
    nxt.y    = op_ry;
    nxt.inf  = op_inf;
    add_call = 1'b0;
    add_sel  = OP_ADD;
    if (state == ADD) begin
      nxt = acc;
      if (bit_set) begin
        if (acc.inf) begin
          nxt.x   = base.x;
          nxt.y   = base.y;
          nxt.inf = 1'b0;
        end else if (x_eq && y_eq) begin
          add_call = 1'b1;        // acc == P: the sum is a doubling of P
          add_sel  = OP_DBL;
        end else if (x_eq) begin
          nxt.inf  = 1'b1;        // acc == -P: the sum is the point at infinity
        end else begin
          add_call = 1'b1;
        end
      end
    end
  end

  assign bit_done = ((state == ADD) && !add_call) || ((state == ADD_W) && op_done);

  // Sequencer state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      base      <= '0;
      k_reg     <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      Rx        <= '0;
      Ry        <= '0;
      R_inf     <= 1'b0;
      op_req    <= 1'b0;
      op_sel    <= 1'b0;
      op_ax     <= '0;
      op_ay     <= '0;
      op_bx     <= '0;
      op_by     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      op_req    <= 1'b0;
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            base.x  <= Px;
            base.y  <= Py;
            base.inf <= 1'b0;
            k_reg   <= k;
            acc.inf <= 1'b1;
            idx     <= IDX_TOP;
            busy    <= 1'b1;
            state   <= DBL;
          end
        end

        DBL: begin
          if (acc.inf) begin
            state <= ADD;                 // doubling infinity is a no-op
          end else begin
            op_req <= 1'b1;
            op_sel <= OP_DBL;
            op_ax  <= acc.x;
            op_ay  <= acc.y;
            state  <= DBL_W;
          end
        end

        DBL_W: begin
          if (op_done) begin
            acc.x   <= op_rx;
            acc.y   <= op_ry;
            acc.inf <= op_inf;
            state   <= ADD;
          end
        end

        ADD, ADD_W: begin
          if (add_call) begin
            op_req <= 1'b1;
            op_sel <= add_sel;
            op_ax  <= (add_sel == OP_DBL) ? base.x : acc.x;
            op_ay  <= (add_sel == OP_DBL) ? base.y : acc.y;
            op_bx  <= base.x;
            op_by  <= base.y;
            state  <= ADD_W;
          end else if (bit_done) begin
            acc <= nxt;
            if (idx == '0) begin
              // Result is presented together with out_valid in the DONE cycle.
              Rx        <= nxt.inf ? '0 : nxt.x;
              Ry        <= nxt.inf ? '0 : nxt.y;
              R_inf     <= nxt.inf;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= idx - CNT_W'(1);
              state <= DBL;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl on the toy curve y^2 = x^3 + 2x + 2 mod 17,
// G = (5,1), order 19, with a behavioural point engine of latency 3.
module tb_scalar_mult_ctrl;

  localparam int DW      = 8;
  localparam int Q       = 17;
  localparam int CURVE_A = 2;
  localparam int ORDER   = 19;
  localparam int ENG_LAT = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       inf;
  } tpt_t;

  typedef struct {
    int         cyc;
    logic [7:0] rx, ry;
    logic       rinf;
    int         ndbl, nadd;
    logic [15:0] seq;
    logic [7:0] ax0, ay0;
    logic       sel0;
  } run_t;

  typedef struct {
    logic [7:0]  kv;
    int          poke;   // 0 none, 1 in_valid while busy, 2 in_valid in DONE cycle
    logic [7:0]  ex, ey;
    logic        einf;
    int          ncyc, ndbl, nadd;
    logic [15:0] seq;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] Px = '0, Py = '0, k = '0;
  logic          busy, out_valid, R_inf, op_req, op_sel;
  logic [DW-1:0] Rx, Ry, op_ax, op_ay, op_bx, op_by;
  logic          op_done = 1'b0;
  logic [DW-1:0] op_rx = '0, op_ry = '0;
  logic          op_inf = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  scalar_mult_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Px(Px), .Py(Py), .k(k),
    .busy(busy), .out_valid(out_valid), .Rx(Rx), .Ry(Ry), .R_inf(R_inf),
    .op_req(op_req), .op_sel(op_sel), .op_ax(op_ax), .op_ay(op_ay),
    .op_bx(op_bx), .op_by(op_by), .op_done(op_done), .op_rx(op_rx),
    .op_ry(op_ry), .op_inf(op_inf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- curve arithmetic ----------------
  function automatic int inv_mod(input int a);
    for (int i = 1; i < Q; i++) if ((a * i) % Q == 1) return i;
    return 0;
  endfunction

  function automatic tpt_t pt_add(input tpt_t a, input tpt_t b);
    int ax, ay, bx, by, lam, x3, y3;
    tpt_t r;
    r = '0;
    r.inf = 1'b1;
    if (a.inf) return b;
    if (b.inf) return a;
    ax = int'(a.x); ay = int'(a.y); bx = int'(b.x); by = int'(b.y);
    if (ax == bx && (ay + by) % Q == 0) return r;
    if (ax == bx) lam = ((3 * ax * ax + CURVE_A) % Q) * inv_mod((2 * ay) % Q) % Q;
    else          lam = ((by - ay + Q) % Q) * inv_mod((bx - ax + Q) % Q) % Q;
    x3 = (lam * lam + 2 * Q - ax - bx) % Q;
    y3 = (lam * ((ax - x3 + Q) % Q) + Q - ay) % Q;
    r.x = 8'(x3);
    r.y = 8'(y3);
    r.inf = 1'b0;
    return r;
  endfunction

  // Reference result: add G to itself (k mod order) times.
  function automatic tpt_t ref_mul(input logic [7:0] kv);
    tpt_t g, r;
    g = '{x: 8'd5, y: 8'd1, inf: 1'b0};
    r = '{x: 8'd0, y: 8'd0, inf: 1'b1};
    for (int i = 0; i < int'(kv) % ORDER; i++) r = pt_add(r, g);
    if (r.inf) begin r.x = '0; r.y = '0; end
    return r;
  endfunction

  // ---------------- behavioural point engine ----------------
  int   eng_cnt = 0;
  tpt_t eng_res;
  always @(posedge clk) begin
    op_done <= 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        op_done <= 1'b1;
        op_rx   <= eng_res.x;
        op_ry   <= eng_res.y;
        op_inf  <= eng_res.inf;
      end
    end
    if (op_req) begin
      eng_cnt <= ENG_LAT - 1;
      if (op_sel) eng_res <= pt_add('{x: op_ax, y: op_ay, inf: 1'b0}, '{x: op_bx, y: op_by, inf: 1'b0});
      else        eng_res <= pt_add('{x: op_ax, y: op_ay, inf: 1'b0}, '{x: op_ax, y: op_ay, inf: 1'b0});
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_op_req"}, 32'(op_req), 0);
    check({tag, "_op_sel"}, 32'(op_sel), 0);
    check({tag, "_R_inf"}, 32'(R_inf), 0);
    check({tag, "_Rxy"}, {16'd0, Rx, Ry}, 0);
    check({tag, "_operands"}, {op_ax, op_ay, op_bx, op_by}, 0);
  endtask

  // One full request: pulse in_valid with P = G, monitor the engine traffic,
  // and collect the result when out_valid appears.
  task automatic run_op(input logic [7:0] kv, input int poke, output run_t r);
    int   start, rel, req_err, stab_err;
    bit   prev_req, pending, got;
    logic [32:0] hold;
    r.cyc = 0; r.rx = '0; r.ry = '0; r.rinf = 1'b0; r.ndbl = 0; r.nadd = 0;
    r.seq = '0; r.ax0 = '0; r.ay0 = '0; r.sel0 = 1'b0;
    req_err = 0; stab_err = 0; prev_req = 0; pending = 0; got = 0; hold = '0;
    @(posedge clk); #1;
    Px = 8'd5; Py = 8'd1; k = kv; in_valid = 1'b1; start = cyc;
    @(negedge clk);
    check("busy_in_accept_cycle", 32'(busy), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; Px = 8'($urandom); Py = 8'($urandom); k = 8'($urandom);
    for (int t = 0; t < 1000 && !got; t++) begin
      @(negedge clk);
      rel = cyc - start;
      in_valid = 1'b0;
      if (rel == 1) check("busy_cycle1", 32'(busy), 1);
      if (pending && {op_ax, op_ay, op_bx, op_by, op_sel} !== hold) stab_err++;
      if (pending && op_done) pending = 0;
      if (op_req) begin
        if (prev_req) req_err++;
        if (r.ndbl + r.nadd == 0) begin r.ax0 = op_ax; r.ay0 = op_ay; r.sel0 = op_sel; end
        r.seq = {r.seq[14:0], op_sel};
        if (op_sel) r.nadd++; else r.ndbl++;
        hold = {op_ax, op_ay, op_bx, op_by, op_sel};
        pending = 1;
      end
      prev_req = op_req;
      if (poke == 1 && rel == 5) begin in_valid = 1'b1; k = 8'd1; Px = 8'd5; Py = 8'd1; end
      if (out_valid) begin
        got = 1;
        r.cyc = rel; r.rx = Rx; r.ry = Ry; r.rinf = R_inf;
        check("busy_in_done_cycle", 32'(busy), 1);
        if (poke == 2) begin in_valid = 1'b1; k = 8'd1; Px = 8'd5; Py = 8'd1; end
      end
    end
    if (!got) check("out_valid_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("out_valid_one_cycle", 32'(out_valid), 0);
    check("busy_after_done", 32'(busy), 0);
    @(negedge clk);
    check("idle_after_done", 32'(busy), 0);
    check("op_req_single_cycle", 32'(req_err), 0);
    check("operand_stability", 32'(stab_err), 0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[8];
  run_t res;
  tpt_t exp_pt;

  initial begin
    tbl[0] = '{8'd1,  0, 8'd5, 8'd1,  1'b0, 17, 0, 0, 16'h0000};
    tbl[1] = '{8'd2,  0, 8'd6, 8'd3,  1'b0, 21, 1, 0, 16'h0000};
    tbl[2] = '{8'd9,  0, 8'd7, 8'd6,  1'b0, 33, 3, 1, 16'h0001};
    tbl[3] = '{8'd19, 0, 8'd0, 8'd0,  1'b1, 37, 4, 1, 16'h0002};
    tbl[4] = '{8'd0,  1, 8'd0, 8'd0,  1'b1, 17, 0, 0, 16'h0000};
    tbl[5] = '{8'd21, 0, 8'd6, 8'd3,  1'b0, 41, 5, 1, 16'h0008};
    tbl[6] = '{8'd18, 2, 8'd5, 8'd16, 1'b0, 37, 4, 1, 16'h0002};
    tbl[7] = '{8'd9,  0, 8'd7, 8'd6,  1'b0, 33, 3, 1, 16'h0001};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].kv, tbl[i].poke, res);
      check($sformatf("k%0d_Rx", tbl[i].kv), 32'(res.rx), 32'(tbl[i].ex));
      check($sformatf("k%0d_Ry", tbl[i].kv), 32'(res.ry), 32'(tbl[i].ey));
      check($sformatf("k%0d_R_inf", tbl[i].kv), 32'(res.rinf), 32'(tbl[i].einf));
      check($sformatf("k%0d_out_cycle", tbl[i].kv), 32'(res.cyc), 32'(tbl[i].ncyc));
      check($sformatf("k%0d_num_dbl", tbl[i].kv), 32'(res.ndbl), 32'(tbl[i].ndbl));
      check($sformatf("k%0d_num_add", tbl[i].kv), 32'(res.nadd), 32'(tbl[i].nadd));
      check($sformatf("k%0d_op_order", tbl[i].kv), 32'(res.seq), 32'(tbl[i].seq));
      if (tbl[i].ndbl + tbl[i].nadd > 0) begin
        check($sformatf("k%0d_first_op", tbl[i].kv), {15'd0, res.sel0, res.ax0, res.ay0}, {16'd0, 8'd5, 8'd1});
      end
    end

    // Reset during the second engine doubling of k=9, then k=2 from the
    // first post-reset cycle.
    begin
      int nreq, start, rel;
      bit got;
      nreq = 0; got = 0;
      @(posedge clk); #1;
      Px = 8'd5; Py = 8'd1; k = 8'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int t = 0; t < 200 && nreq < 2; t++) begin
        @(negedge clk);
        if (op_req) nreq++;
      end
      check("rst_test_reached_second_dbl", 32'(nreq), 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; Px = 8'd5; Py = 8'd1; k = 8'd2; in_valid = 1'b1; start = cyc;
      @(negedge clk);
      check_reset_outputs("mid_op_reset");
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("accept_first_post_reset_cycle", 32'(busy), 1);
      rel = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (out_valid) begin
          got = 1;
          rel = cyc - start;
          check("post_reset_k2_Rx", 32'(Rx), 6);
          check("post_reset_k2_Ry", 32'(Ry), 3);
          check("post_reset_k2_R_inf", 32'(R_inf), 0);
        end
      end
      if (!got) check("post_reset_out_valid_timeout", 0, 1);
      check("post_reset_k2_out_cycle", 32'(rel), 21);
      repeat (2) @(posedge clk);
    end

    // Random scalars against the repeated-addition reference.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] kv;
      kv = 8'($urandom_range(0, 255));
      exp_pt = ref_mul(kv);
      run_op(kv, 0, res);
      check($sformatf("rand_k%0d_Rx", kv), 32'(res.rx), 32'(exp_pt.x));
      check($sformatf("rand_k%0d_Ry", kv), 32'(res.ry), 32'(exp_pt.y));
      check($sformatf("rand_k%0d_R_inf", kv), 32'(res.rinf), 32'(exp_pt.inf));
      check($sformatf("rand_k%0d_out_cycle", kv), 32'(res.cyc),
            32'(2 * DW + 1 + (1 + ENG_LAT) * (res.ndbl + res.nadd)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
